// File: rtl/cache_flash_arb.sv
// cache_flash_arb
// Shares the single flash slave port between the instruction cache (requester 0)
// and the data cache (requester 1). Each requester may have one pending request.
// Demand reads beat prefetch reads. A prefetch that loses AGE_MAX arbitrations is
// promoted to demand class. Read data is routed back to the owning requester.
//
// Build option (macro): CACHE_ARB_RR_EN
//   defined   : round-robin tie-break within a class (pointer favours the
//               requester not granted last; resets to favour requester 0)
//   undefined : fixed tie-break, requester 0 wins; no pointer register
//
// Protocol checks are in cache_flash_arb_chk, at the bottom of this file.

module cache_flash_arb #(
  parameter int AGE_MAX = 4
) (
  input  logic        i_hclk,
  input  logic        i_hnreset,
  input  logic        i_r0_en,
  input  logic [29:0] i_r0_addr,
  input  logic        i_r0_pref,
  input  logic        i_r0_cancel,
  output logic        o_r0_ready,
  output logic [31:0] o_r0_rdata,
  input  logic        i_r1_en,
  input  logic [29:0] i_r1_addr,
  input  logic        i_r1_pref,
  input  logic        i_r1_cancel,
  output logic        o_r1_ready,
  output logic [31:0] o_r1_rdata,
  output logic        o_sl_en,
  output logic [29:0] o_sl_addr,
  input  logic        i_sl_ready,
  input  logic [31:0] i_sl_rdata,
  output logic        o_grant,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_t;

  localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);
  localparam logic [3:0] AGE_SAT = 4'd15;

  // Transaction state and last owner
  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_grant;

  // Pending request registers, one slot per requester
  logic [1:0]  r_valid;
  logic [1:0]  r_pref;
  logic [29:0] r_addr [2];
  logic [3:0]  r_age  [2];

  // Requester inputs gathered into per-index vectors
  logic [1:0]  w_en;
  logic [1:0]  w_cancel;
  logic [1:0]  w_pref_in;
  logic [29:0] w_addr_in [2];

  // Arbitration and handshake helpers
  logic [1:0]  w_demand;
  logic [1:0]  w_ready;
  logic [1:0]  w_done;
  logic [1:0]  w_capture;
  logic        w_sel;
  logic        w_tie;
  logic        w_issue;

  assign w_en         = {i_r1_en, i_r0_en};
  assign w_cancel     = {i_r1_cancel, i_r0_cancel};
  assign w_pref_in    = {i_r1_pref, i_r0_pref};
  assign w_addr_in[0] = i_r0_addr;
  assign w_addr_in[1] = i_r1_addr;

`ifdef CACHE_ARB_RR_EN
  logic r_rr_ptr;

  // Round-robin pointer: after every issue, favour the requester that lost.
  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) begin
      r_rr_ptr <= 1'b0;
    end else if (w_issue) begin
      r_rr_ptr <= ~w_sel;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  assign w_tie = r_rr_ptr;
`else
  assign w_tie = 1'b0;
`endif

  // Effective class: a pending prefetch counts as demand once it has aged out.
  always_comb begin
    w_demand = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_demand[i] = r_valid[i] & (~r_pref[i] | (r_age[i] >= AGE_LIM));
    end
  end

  // Winner selection: lone requester, then demand over prefetch, then tie-break.
  always_comb begin
    w_sel = 1'b0;
    if (r_valid[0] && !r_valid[1]) begin
      w_sel = 1'b0;
    end else if (!r_valid[0] && r_valid[1]) begin
      w_sel = 1'b1;
    end else if (w_demand[0] != w_demand[1]) begin
      w_sel = w_demand[1];
    end else begin
      w_sel = w_tie;
    end
  end

  // FSM next state: issue from IDLE when the slave is idle, finish on slave ready.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if ((|r_valid) && i_sl_ready) begin
          w_issue     = 1'b1;
          w_state_nxt = w_sel ? ST_BUSY1 : ST_BUSY0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY0: begin
        if (i_sl_ready) begin
          w_done[0]   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY0;
        end
      end
      ST_BUSY1: begin
        if (i_sl_ready) begin
          w_done[1]   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register; reset abandons any outstanding transaction.
  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Owner of the current or most recent transaction.
  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) begin
      r_grant <= 1'b0;
    end else if (w_issue) begin
      r_grant <= w_sel;
    end else begin
      r_grant <= r_grant;
    end
  end

  // A requester can accept when nothing is pending or outstanding for it,
  // or when its data is returning in this very cycle.
  assign w_ready[0]   = (~r_valid[0] & (r_state != ST_BUSY0)) | w_done[0];
  assign w_ready[1]   = (~r_valid[1] & (r_state != ST_BUSY1)) | w_done[1];
  assign w_capture    = w_en & w_ready;

  // Pending slots: capture beats issue and cancel; losers of an issue age.
  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) begin
      r_valid <= 2'b00;
      r_pref  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_addr[i] <= 30'd0;
        r_age[i]  <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_capture[i]) begin
          r_valid[i] <= 1'b1;
          r_pref[i]  <= w_pref_in[i];
          r_addr[i]  <= w_addr_in[i];
          r_age[i]   <= 4'd0;
        end else if (w_issue && (w_sel == i[0])) begin
          r_valid[i] <= 1'b0;
        end else begin
          if (w_cancel[i]) begin
            r_valid[i] <= 1'b0;
          end
          if (w_issue && r_valid[i] && r_pref[i] && (r_age[i] != AGE_SAT)) begin
            r_age[i] <= r_age[i] + 4'd1;
          end
        end
      end
    end
  end

  // Slave side and status outputs
  assign o_sl_en    = w_issue;
  assign o_sl_addr  = w_issue ? r_addr[w_sel] : 30'd0;
  assign o_grant    = w_issue ? w_sel : r_grant;
  assign o_busy     = (r_state != ST_IDLE);

  // Requester side outputs; read data is only passed through on completion
  assign o_r0_ready = w_ready[0];
  assign o_r1_ready = w_ready[1];
  assign o_r0_rdata = w_done[0] ? i_sl_rdata : 32'd0;
  assign o_r1_rdata = w_done[1] ? i_sl_rdata : 32'd0;

  cache_flash_arb_chk u_chk (
    .i_hclk     (i_hclk),
    .i_hnreset  (i_hnreset),
    .i_r0_en    (i_r0_en),
    .i_r0_ready (o_r0_ready),
    .i_r1_en    (i_r1_en),
    .i_r1_ready (o_r1_ready),
    .i_sl_en    (o_sl_en),
    .i_sl_ready (i_sl_ready),
    .i_busy     (o_busy)
  );

endmodule

// cache_flash_arb_chk
// Protocol assertions for cache_flash_arb; no functional logic.
module cache_flash_arb_chk (
  input logic i_hclk,
  input logic i_hnreset,
  input logic i_r0_en,
  input logic i_r0_ready,
  input logic i_r1_en,
  input logic i_r1_ready,
  input logic i_sl_en,
  input logic i_sl_ready,
  input logic i_busy
);

  // A request strobe is only legal while the requester reports ready.
  a_r0_en_ready: assert property (@(posedge i_hclk) disable iff (!i_hnreset)
    i_r0_en |-> i_r0_ready);
  a_r1_en_ready: assert property (@(posedge i_hclk) disable iff (!i_hnreset)
    i_r1_en |-> i_r1_ready);

  // A new slave request is never launched over an outstanding one.
  a_issue_idle: assert property (@(posedge i_hclk) disable iff (!i_hnreset)
    i_sl_en |-> !i_busy);

  // The slave must drop ready in the cycle after a request strobe.
  a_slave_busy: assert property (@(posedge i_hclk) disable iff (!i_hnreset)
    i_sl_en |=> !i_sl_ready);

endmodule

// File: doc/cache_flash_arb.md
# cache_flash_arb

Arbiter that shares the single flash slave port between two cache controllers, requester 0 (instruction cache) and requester 1 (data cache). Each controller issues single-word refill or prefetch reads. The arbiter queues one request per requester, grants the slave by priority class, and routes the returned data back to the owner. It sits between the controllers' slave-side outputs (enable, word address) and the flash slave.

## Interface
- AGE_MAX, 4: number of lost arbitrations after which a pending prefetch is promoted to demand class (1..15).
- i_hclk  in  1  clock.
- i_hnreset  in  1  asynchronous, active-low reset.
- i_rN_en  in  1  (N=0,1) request pulse. Valid only while o_rN_ready=1.
- i_rN_addr  in  30  word address, sampled with i_rN_en.
- i_rN_pref  in  1  1 = prefetch class, 0 = demand class. Sampled with i_rN_en.
- i_rN_cancel  in  1  drops requester N's pending request if it has not yet been issued.
- o_rN_ready  out  1  requester N has nothing pending or outstanding, or its data returns this cycle.
- o_rN_rdata  out  32  returned word, valid when o_rN_ready rises from completion; 0 otherwise.
- o_sl_en  out  1  one-cycle slave request strobe.
- o_sl_addr  out  30  slave word address.
- i_sl_ready  in  1  slave idle, or data valid at completion.
- i_sl_rdata  in  32  slave read data.
- o_grant  out  1  owner of the current or last transaction (0/1).
- o_busy  out  1  a slave transaction is outstanding.

## Operation
- Per-requester pending register holds: valid, addr[29:0], pref, age[3:0].
- Capture:
  - i_rN_en with o_rN_ready=1 sets valid, loads addr and pref, and clears age.
  - i_rN_en with o_rN_ready=0 is ignored and flagged by an assertion.
- Cancel: i_rN_cancel clears valid only if the request has not been issued. Cancel is ignored for an outstanding request. If en and cancel arrive in the same cycle, en wins.
- FSM states IDLE, BUSY0, BUSY1. Reset state is IDLE.
  - IDLE to BUSYg when any valid=1 and i_sl_ready=1. In that cycle: o_sl_en=1, o_sl_addr=addr of g, valid of g cleared, o_grant=g.
  - BUSYg to IDLE when i_sl_ready=1. In that cycle: o_rg_ready=1, o_rg_rdata=i_sl_rdata, o_busy drops the next cycle.
  - Slave contract: i_sl_ready=0 from the cycle after o_sl_en until completion. A completion of at least one cycle is required.
- Grant selection:
  - Effective class: demand if pref=0 or age>=AGE_MAX, otherwise prefetch.
  - Demand beats prefetch.
  - Within the same class: round-robin pointer, favouring the requester not granted last. Pointer resets to favour requester 0.
- Ageing: each issue cycle where requester N is valid, not granted, and has pref=1 increments age_N, saturating at 15.
- o_rN_ready = !valid_N && !(state==BUSYN), or completion of N this cycle.
- Reset mid-transaction:
  - All pending requests are lost and the state returns to IDLE.
  - A late i_sl_ready from the slave is ignored in IDLE.
  - The system resets the slave together with the arbiter.

## Timing
- Reset values:
  - o_sl_en=0, o_sl_addr=0, o_rN_ready=1, o_rN_rdata=0, o_grant=0, o_busy=0.
- Latency: i_rN_en at cycle t gives the earliest o_sl_en at t+1 (the pending register is registered).
- Back-to-back: completion at cycle c gives the next o_sl_en at the earliest at c+1. The slave has one idle cycle between transactions.
- Output timing:
  - o_sl_en and o_sl_addr are combinational from state, pending registers and i_sl_ready.
  - o_rN_rdata is combinational from i_sl_rdata.
- Simultaneous events:
  - Completion and a new i_rN_en for the same N in one cycle: accepted. o_rN_ready=1 that cycle, and the new request is pending at c+1.
  - Two requests in the same cycle: both captured, and arbitration happens at t+1.

## Configuration
- CACHE_ARB_RR_EN:
  - Defined: round-robin within a class, as above.
  - Undefined: fixed priority within a class, requester 0 beats requester 1. The pointer register is removed. Ageing and class priority are unchanged.

## Test plan
- Single demand: r0_en with addr 0x0000_0100 and pref=0.
  - Expect o_sl_en at t+1 with o_sl_addr=0x100 and r0_ready=0.
  - Slave returns 0xDEAD_BEEF after 3 cycles: r0_ready=1 and r0_rdata=0xDEADBEEF that cycle. r1 is untouched.
- Same-cycle requests: r0 prefetch 0x10, r1 demand 0x20.
  - r1 is issued first, then r0 issued at completion+1. o_grant goes 1 then 0.
- Round-robin: both demand, repeated 4 times (r0 and r1 re-requesting at completion).
  - Grant alternates 0,1,0,1.
  - With CACHE_ARB_RR_EN undefined, the grant is 0 whenever both are pending.
- Ageing with AGE_MAX=2: r1 prefetch pending while r0 issues demand 3 times back-to-back.
  - r1 is promoted after 2 lost arbitrations and wins on the third.
- Cancel:
  - r0 prefetch 0x40 is pending behind an r1 transaction, then r0_cancel: 0x40 is never issued and r0_ready returns to 1 next cycle.
  - Cancel of an outstanding request: no effect, data is still returned.
- Reset mid-transaction: assert i_hnreset while in BUSY0.
  - All outputs are at reset values immediately.
  - A stray i_sl_ready after release produces no o_r0_ready pulse and no o_sl_en.
